// File: rtl/bsg_manycore_link_to_axil_rx.sv
// bsg_manycore_link_to_axil_rx
//   Host-bound half of the AXI-Lite host link. Buffers full-width manycore
//   packets in a small FIFO and serializes each into axil_data_width_p words
//   (word 0 = LSBs) for the host's AXI-Lite read-data path. rx_words_o counts
//   words held in buffer + serializer so the host knows how many reads it may
//   issue.
// Ports
//   clk_i, reset_n_i            clock, synchronous active-low reset
//   fifo_req_i/_v_i/_ready_o    packet input from the endpoint
//   axil_rsp_o/_v_o/_ready_i    word output to the host
//   rx_words_o                  buffered word count
//   rx_pkt_cnt_o                accepted-packet counter
// Configuration
//   BSG_MANYCORE_LINK_RX_PKT_CNT_EN: when defined, rx_pkt_cnt_o is a wrapping
//   32-bit accepted-packet counter; otherwise it is tied to 0.
module bsg_manycore_link_to_axil_rx #(
  parameter int host_fifo_width_p = 128,
  parameter int axil_data_width_p = 32,
  parameter int rx_fifo_els_p     = 4,
  localparam int ratio_lp     = host_fifo_width_p / axil_data_width_p,
  localparam int cnt_width_lp = $clog2(ratio_lp * (rx_fifo_els_p + 1) + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [host_fifo_width_p-1:0] fifo_req_i,
  input  logic                         fifo_req_v_i,
  output logic                         fifo_req_ready_o,
  output logic [axil_data_width_p-1:0] axil_rsp_o,
  output logic                         axil_rsp_v_o,
  input  logic                         axil_rsp_ready_i,
  output logic [cnt_width_lp-1:0]      rx_words_o,
  output logic [31:0]                  rx_pkt_cnt_o
);

  localparam int ptr_width_lp  = (rx_fifo_els_p > 1) ? $clog2(rx_fifo_els_p) : 1;
  localparam int fcnt_width_lp = $clog2(rx_fifo_els_p + 1);
  localparam int w_width_lp    = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
  localparam logic [w_width_lp-1:0]   w_last_lp  = w_width_lp'(ratio_lp - 1);
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(rx_fifo_els_p - 1);
  localparam logic [fcnt_width_lp-1:0] fifo_full_lp = fcnt_width_lp'(rx_fifo_els_p);

  typedef enum logic {IDLE, SEND} state_e;

  typedef logic [ratio_lp-1:0][axil_data_width_p-1:0] pkt_t;

  // input buffer
  pkt_t [rx_fifo_els_p-1:0]  mem_q;
  logic [ptr_width_lp-1:0]   wr_ptr_q, rd_ptr_q;
  logic [fcnt_width_lp-1:0]  fcnt_q;
  logic                      fifo_empty, push, pop;

  // serializer
  state_e                    state_q, state_d;
  logic [w_width_lp-1:0]     w_q, w_d;
  pkt_t                      pkt_q, pkt_d;
  logic                      hs;

  logic [cnt_width_lp-1:0]   words_q, words_d;

  assign fifo_empty       = (fcnt_q == '0);
  assign fifo_req_ready_o = reset_n_i && (fcnt_q != fifo_full_lp);
  assign push             = fifo_req_v_i & fifo_req_ready_o;
  assign hs               = (state_q == SEND) & axil_rsp_ready_i;

  assign axil_rsp_v_o = reset_n_i && (state_q == SEND);
  assign axil_rsp_o   = pkt_q[w_q];
  assign rx_words_o   = reset_n_i ? words_q : '0;

  // data array carries no reset; occupancy is tracked by pointers/count
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= fifo_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == ptr_last_lp) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == ptr_last_lp) ? '0 : rd_ptr_q + 1'b1;
      fcnt_q <= fcnt_q + fcnt_width_lp'(push) - fcnt_width_lp'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    pkt_d   = pkt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          pkt_d   = mem_q[rd_ptr_q];
          w_d     = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (axil_rsp_ready_i) begin
          if (w_q != w_last_lp) begin
            w_d = w_q + 1'b1;
          end else if (!fifo_empty) begin
            // reload on the last word so back-to-back packets have no bubble
            pop   = 1'b1;
            pkt_d = mem_q[rd_ptr_q];
            w_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // a push and a word handshake in the same cycle net to +(ratio_lp-1)
  always_comb begin
    words_d = words_q;
    if (push) words_d = words_d + cnt_width_lp'(ratio_lp);
    if (hs)   words_d = words_d - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      w_q     <= '0;
      pkt_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      pkt_q   <= pkt_d;
      words_q <= words_d;
    end
  end

`ifdef BSG_MANYCORE_LINK_RX_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) pkt_cnt_q <= '0;
    else if (push)  pkt_cnt_q <= pkt_cnt_q + 32'd1;
  end
  assign rx_pkt_cnt_o = reset_n_i ? pkt_cnt_q : '0;
`else
  assign rx_pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_link_to_axil_rx.sv
module tb_bsg_manycore_link_to_axil_rx;
  localparam int HW = 128;
  localparam int AW = 32;
  localparam int EL = 4;
  localparam int CW = $clog2(4 * (EL + 1) + 1);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [HW-1:0] fifo_req_i;
  logic          fifo_req_v_i;
  logic          fifo_req_ready_o;
  logic [AW-1:0] axil_rsp_o;
  logic          axil_rsp_v_o;
  logic          axil_rsp_ready_i;
  logic [CW-1:0] rx_words_o;
  logic [31:0]   rx_pkt_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  bsg_manycore_link_to_axil_rx #(
    .host_fifo_width_p(HW), .axil_data_width_p(AW), .rx_fifo_els_p(EL)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .fifo_req_i(fifo_req_i), .fifo_req_v_i(fifo_req_v_i),
    .fifo_req_ready_o(fifo_req_ready_o),
    .axil_rsp_o(axil_rsp_o), .axil_rsp_v_o(axil_rsp_v_o),
    .axil_rsp_ready_i(axil_rsp_ready_i),
    .rx_words_o(rx_words_o), .rx_pkt_cnt_o(rx_pkt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [AW-1:0] wrd(input int p, input int k);
    return 32'hA000_0000 | (p << 8) | k;
  endfunction

  function automatic logic [HW-1:0] mkpkt(input int p);
    logic [HW-1:0] r;
    for (int k = 0; k < 4; k++) r[k*AW +: AW] = wrd(p, k);
    return r;
  endfunction

  initial begin
    int acc;
    logic [HW-1:0] p1;
    reset_n_i = 1'b0; fifo_req_i = '0; fifo_req_v_i = 1'b0; axil_rsp_ready_i = 1'b0;
    p1 = 128'h44444444_33333333_22222222_11111111;
    tick(); tick(); tick();
    chk("rst_ready", fifo_req_ready_o, 0);
    chk("rst_v", axil_rsp_v_o, 0);
    chk("rst_words", rx_words_o, 0);
    chk("rst_pktcnt", rx_pkt_cnt_o, 0);
    reset_n_i = 1'b1;
    tick();
    chk("idle_ready", fifo_req_ready_o, 1);
    chk("idle_v", axil_rsp_v_o, 0);

    // single packet, split LSB word first
    axil_rsp_ready_i = 1'b1;
    fifo_req_i = p1; fifo_req_v_i = 1'b1;
    tick();
    fifo_req_v_i = 1'b0;
    chk("t1_lat_v", axil_rsp_v_o, 0);
    chk("t1_lat_words", rx_words_o, 4);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_v", axil_rsp_v_o, 1);
      chk("t1_data", axil_rsp_o, p1[k*AW +: AW]);
      chk("t1_words", rx_words_o, 4 - k);
      tick();
    end
    chk("t1_end_v", axil_rsp_v_o, 0);
    chk("t1_end_words", rx_words_o, 0);

    // host stalled: only 5 of 7 offered packets fit
    axil_rsp_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      fifo_req_i = mkpkt(i); fifo_req_v_i = 1'b1;
      if (fifo_req_ready_o) acc++;
      tick();
    end
    fifo_req_v_i = 1'b0;
    chk("t2_accepted", acc, 5);
    chk("t2_ready", fifo_req_ready_o, 0);
    chk("t2_words", rx_words_o, 20);
    chk("t2_v", axil_rsp_v_o, 1);
    chk("t2_hold", axil_rsp_o, wrd(0, 0));
    tick();
    chk("t2_hold2", axil_rsp_o, wrd(0, 0));

    // drain: 20 back-to-back words across 5 packet boundaries
    axil_rsp_ready_i = 1'b1;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++) begin
        chk("t4_v", axil_rsp_v_o, 1);
        chk("t4_data", axil_rsp_o, wrd(i, k));
        tick();
      end
    chk("t4_end_v", axil_rsp_v_o, 0);
    chk("t4_end_words", rx_words_o, 0);

    // simultaneous accept and word pop: 3 -> 6
    fifo_req_i = p1; fifo_req_v_i = 1'b1;
    tick();
    fifo_req_v_i = 1'b0;
    tick(); tick();
    chk("t3_pre_words", rx_words_o, 3);
    fifo_req_i = mkpkt(9); fifo_req_v_i = 1'b1;
    tick();
    fifo_req_v_i = 1'b0;
    chk("t3_words", rx_words_o, 6);
    chk("t3_data2", axil_rsp_o, p1[2*AW +: AW]);
    tick();
    chk("t3_data3", axil_rsp_o, p1[3*AW +: AW]);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t3_v9", axil_rsp_v_o, 1);
      chk("t3_data9", axil_rsp_o, wrd(9, k));
      tick();
    end
    chk("t3_end_v", axil_rsp_v_o, 0);
`ifdef BSG_MANYCORE_LINK_RX_PKT_CNT_EN
    chk("pktcnt_8", rx_pkt_cnt_o, 8);
`else
    chk("pktcnt_off", rx_pkt_cnt_o, 0);
`endif

    // reset mid-packet discards the partial packet
    axil_rsp_ready_i = 1'b0;
    fifo_req_i = mkpkt(20); fifo_req_v_i = 1'b1;
    tick();
    fifo_req_v_i = 1'b0;
    tick(); tick();
    axil_rsp_ready_i = 1'b1;
    tick(); tick();
    axil_rsp_ready_i = 1'b0;
    chk("t5_mid_data", axil_rsp_o, wrd(20, 2));
    chk("t5_mid_words", rx_words_o, 2);
    reset_n_i = 1'b0;
    tick();
    chk("t5_rst_v", axil_rsp_v_o, 0);
    chk("t5_rst_words", rx_words_o, 0);
    chk("t5_rst_ready", fifo_req_ready_o, 0);
    chk("t5_rst_pktcnt", rx_pkt_cnt_o, 0);
    reset_n_i = 1'b1;
    tick();
    axil_rsp_ready_i = 1'b1;
    fifo_req_i = mkpkt(21); fifo_req_v_i = 1'b1;
    tick();
    fifo_req_v_i = 1'b0;
    tick();
    chk("t5_new_v", axil_rsp_v_o, 1);
    chk("t5_new_data", axil_rsp_o, wrd(21, 0));
    chk("t5_new_words", rx_words_o, 4);
`ifdef BSG_MANYCORE_LINK_RX_PKT_CNT_EN
    chk("pktcnt_1", rx_pkt_cnt_o, 1);
`else
    chk("pktcnt_off2", rx_pkt_cnt_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
